// File: rtl/video_timing_gen.sv
// Pixel-clock video timing generator: raster counters, registered position and
// sync decode, and a run/stop controller that starts on a frame boundary and
// always completes the frame in progress before stopping.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | counters parked at (0,0), outputs at idle levels
//   RUN      | counters advancing, run request still present
//   STOPPING | run request dropped, finishing the current frame
module video_timing_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        I_pix_clk,
    input  logic        I_rst_n,
    input  logic        I_enable,
    output logic [11:0] O_active_x,
    output logic [11:0] O_active_y,
    output logic        O_de,
    output logic        O_hs,
    output logic        O_vs,
    output logic        O_frame_start,
    output logic        O_line_start,
    output logic [15:0] O_frame_cnt,
    output logic        O_running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [11:0] h_nxt;
    logic [11:0] v_nxt;
    logic        active;
    logic        at_last;

    // The raster advances whenever a frame is in flight, and also on the very
    // cycle the run request is first seen so (0,0) is output right away.
    always_comb begin
        active    = (state != IDLE) || I_enable;
        at_last   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
        state_nxt = state;
        case (state)
            IDLE: begin
                if (I_enable) state_nxt = RUN;
            end
            RUN: begin
                if (!I_enable) state_nxt = STOPPING;
            end
            STOPPING: begin
                if (I_enable)     state_nxt = RUN;
                else if (at_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next raster position; wrapping from the last position lands on (0,0),
    // which is also where the counters park when the controller goes idle.
    always_comb begin
        h_nxt = 12'd0;
        v_nxt = 12'd0;
        if (active) begin
            if (h_cnt == H_LAST) begin
                h_nxt = 12'd0;
                v_nxt = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_nxt = h_cnt + 12'd1;
                v_nxt = v_cnt;
            end
        end
    end

    // Controller state and raster counters.
    always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= IDLE;
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Registered decode of the current position; all outputs share one stage
    // so de, syncs and coordinates stay aligned.
    always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_active_x    <= 12'd0;
            O_active_y    <= 12'd0;
            O_de          <= 1'b0;
            O_hs          <= ~HS_POL;
            O_vs          <= ~VS_POL;
            O_frame_start <= 1'b0;
            O_line_start  <= 1'b0;
        end else if (active) begin
            O_active_x    <= (h_cnt < H_ACT_C) ? h_cnt : 12'd0;
            O_active_y    <= (v_cnt < V_ACT_C) ? v_cnt : 12'd0;
            O_de          <= (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
            O_hs          <= ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
            O_vs          <= ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
            O_frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
            O_line_start  <= (h_cnt == 12'd0) && (v_cnt < V_ACT_C);
        end else begin
            O_active_x    <= 12'd0;
            O_active_y    <= 12'd0;
            O_de          <= 1'b0;
            O_hs          <= ~HS_POL;
            O_vs          <= ~VS_POL;
            O_frame_start <= 1'b0;
            O_line_start  <= 1'b0;
        end
    end

    // Completed-frame count; bumps as the last position of a frame goes out.
    always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_frame_cnt <= 16'd0;
        end else if ((state != IDLE) && at_last) begin
            O_frame_cnt <= O_frame_cnt + 16'd1;
        end
    end

    assign O_running = (state != IDLE);

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen using a reduced raster so many frames fit in a
// short run. A position-index model predicts every output each cycle; two DUT
// copies cover both sync polarities.
module tb_video_timing_gen;

    localparam int HA = 16, HF = 3, HSW = 4, HB = 5;
    localparam int VA = 10, VF = 2, VSW = 2, VB = 3;
    localparam int HT = HA + HF + HSW + HB;   // 28
    localparam int VT = VA + VF + VSW + VB;   // 17
    localparam int FR = HT * VT;              // 476

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    logic [11:0] x0, y0, x1, y1;
    logic        de0, hs0, vs0, fs0, ls0, run0;
    logic        de1, hs1, vs1, fs1, ls1, run1;
    logic [15:0] fc0, fc1;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_pos (
        .I_pix_clk(clk), .I_rst_n(rst_n), .I_enable(en),
        .O_active_x(x0), .O_active_y(y0), .O_de(de0), .O_hs(hs0), .O_vs(vs0),
        .O_frame_start(fs0), .O_line_start(ls0), .O_frame_cnt(fc0), .O_running(run0)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_neg (
        .I_pix_clk(clk), .I_rst_n(rst_n), .I_enable(en),
        .O_active_x(x1), .O_active_y(y1), .O_de(de1), .O_hs(hs1), .O_vs(vs1),
        .O_frame_start(fs1), .O_line_start(ls1), .O_frame_cnt(fc1), .O_running(run1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: p is the index of the next raster position to emit
    // (row-major over the frame), busy says a frame is in flight, req_last is
    // the last sampled run request while busy.
    int p = 0;
    bit busy = 0, req_last = 0;
    int fcnt = 0;
    int e_x = 0, e_y = 0;
    bit e_de = 0, e_hs = 0, e_vs = 0, e_fs = 0, e_ls = 0, e_run = 0;

    task automatic show_pos(input int q);
        int h, v;
        h    = q % HT;
        v    = q / HT;
        e_de = (h < HA) && (v < VA);
        e_x  = (h < HA) ? h : 0;
        e_y  = (v < VA) ? v : 0;
        e_hs = (h >= HA + HF) && (h < HA + HF + HSW);
        e_vs = (v >= VA + VF) && (v < VA + VF + VSW);
        e_fs = (q == 0);
        e_ls = (h == 0) && (v < VA);
    endtask

    task automatic show_idle();
        e_de = 0; e_x = 0; e_y = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_ls = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit e, act, last;
        if (!rst_n) begin
            p = 0; busy = 0; req_last = 0; fcnt = 0; e_run = 0;
            show_idle();
        end else begin
            e    = en;
            act  = busy || e;
            last = (p == FR - 1);
            if (act) begin
                show_pos(p);
                if (last && busy) fcnt = (fcnt + 1) % 65536;
                p = (p + 1) % FR;
            end else begin
                show_idle();
            end
            if (!busy) busy = e;
            else if (last && !req_last && !e) busy = 0;
            req_last = e;
            e_run    = busy;
        end
    end

    bit cmp_on = 0;

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("x",      x0,   e_x);
            chk("y",      y0,   e_y);
            chk("de",     de0,  int'(e_de));
            chk("hs",     hs0,  int'(e_hs));
            chk("vs",     vs0,  int'(e_vs));
            chk("fstart", fs0,  int'(e_fs));
            chk("lstart", ls0,  int'(e_ls));
            chk("fcnt",   fc0,  fcnt);
            chk("run",    run0, int'(e_run));
            chk("hs_neg", hs1,  int'(!e_hs));
            chk("vs_neg", vs1,  int'(!e_vs));
            chk("de_neg", de1,  int'(e_de));
            chk("fcnt_neg", fc1, fcnt);
        end
    end

    task automatic wait_y(input int row, input int budget);
        int n = 0;
        while (!(y0 == row && de0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("wait_y_timeout", 1, 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (run0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("wait_idle_timeout", 1, 0);
    endtask

    initial begin
        int de_n, hs_n, vs_n, fs_n, kind, len;

        cmp_on = 1;
        repeat (3) @(negedge clk);
        chk("rst_de",   de0,  0);
        chk("rst_hs",   hs0,  0);
        chk("rst_hsn",  hs1,  1);
        chk("rst_vsn",  vs1,  1);
        chk("rst_fcnt", fc0,  0);
        chk("rst_run",  run0, 0);

        rst_n = 1;
        repeat (2) @(negedge clk);
        chk("idle_hold_run", run0, 0);
        en = 1;
        @(negedge clk);
        chk("first_de", de0,  1);
        chk("first_x",  x0,   0);
        chk("first_y",  y0,   0);
        chk("first_fs", fs0,  1);
        chk("first_run", run0, 1);

        de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
        for (int i = 0; i < FR; i++) begin
            de_n += int'(de0); hs_n += int'(hs0); vs_n += int'(vs0); fs_n += int'(fs0);
            @(negedge clk);
        end
        chk("frame_de_cycles", de_n, 160);
        chk("frame_hs_cycles", hs_n, 68);
        chk("frame_vs_cycles", vs_n, 56);
        chk("frame_fs_pulses", fs_n, 1);
        chk("frame_cnt_1",     fc0,  1);

        // stop mid-frame: the frame in progress must complete
        wait_y(5, 2 * FR);
        en = 0;
        @(negedge clk);
        chk("stopping_run", run0, 1);
        wait_idle(2 * FR);
        chk("stop_fcnt", fc0, 2);
        @(negedge clk);
        chk("stop_de", de0, 0);
        chk("stop_hs", hs0, 0);
        chk("stop_hsn", hs1, 1);

        // toggle within a frame, then async reset mid-frame
        en = 1;
        wait_y(3, 2 * FR);
        en = 0;
        repeat (7) @(negedge clk);
        en = 1;
        wait_y(4, 2 * FR);
        #2 rst_n = 0;
        #1;
        chk("arst_de",   de0,  0);
        chk("arst_x",    x0,   0);
        chk("arst_fcnt", fc0,  0);
        chk("arst_run",  run0, 0);
        chk("arst_vsn",  vs1,  1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("restart_x",  x0,  0);
        chk("restart_y",  y0,  0);
        chk("restart_fs", fs0, 1);

        // randomized run requests, fast toggling and occasional resets
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                en  = 1'($urandom_range(0, 1));
                len = $urandom_range(1, 400);
                repeat (len) @(negedge clk);
            end else if (kind < 9) begin
                for (int k = 0; k < 20; k++) begin
                    en = ~en;
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                end
            end else begin
                #2 rst_n = 0;
                @(negedge clk);
                rst_n = 1;
                @(negedge clk);
            end
        end

        en = 0;
        wait_idle(2 * FR);
        repeat (3) @(negedge clk);
        chk("final_run", run0, 0);
        cmp_on = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
